cache_fill_fsm: RTL and testbench
=================================

// Module: cache_fill_fsm
// PURPOSE
//  Miss-handling fill engine that sits between mem_cache_interface and main memory.
//  On miss_detected it reads the whole 16-byte block containing miss_address as
//  8 pipelined 16-bit reads, one read issued per cycle.
//  Each returning word is steered into the missing cache through write_data_array / fill_addr.
//  After the last word it raises write_tag_array. fsm_busy stalls the pipeline for the whole fill.
// PARAMETERS
//  WORDS_PER_BLOCK  8   16-bit words per cache block (power of 2)
//  ADDR_W           16  byte-address width
// PORTS
//  clk                input   1       system clock, rising edge
//  rst                input   1       asynchronous, active-low reset
//  miss_detected      input   1       D- or I-cache miss (from mem_cache_interface)
//  miss_address       input   ADDR_W  byte address that missed
//  memory_data_valid  input   1       memory returns a word this cycle (in request order)
//  fsm_busy           output  1       fill in progress; stall pipeline
//  mem_rd_en          output  1       read request to memory this cycle
//  mem_addr           output  ADDR_W  read address to memory
//  fill_addr          output  ADDR_W  cache byte address for the returning word
//  write_data_array   output  1       write the returning word into the cache data array
//  write_tag_array    output  1       write the tag / valid bit for the filled block
//  fill_count         output  16      completed fills, saturating (only with FILL_STATS_EN)
// BEHAVIOUR
//  - States: IDLE, FILL.
//    - IDLE->FILL when miss_detected is sampled high.
//    - FILL->IDLE on the cycle the WORDS_PER_BLOCK-th valid word arrives.
//  - IDLE->FILL transition latches base = {miss_address[ADDR_W-1:4], 4'b0} and clears
//    issue_cnt and recv_cnt. Both counters are $clog2(WORDS_PER_BLOCK)+1 bits wide.
//  - mem_rd_en = (state==FILL) & (issue_cnt < WORDS_PER_BLOCK).
//    - mem_addr = base + {issue_cnt, 1'b0}; issue_cnt increments on each issued read.
//    - Reads therefore go out on fill cycles 1..8. Memory latency is not counted; only valid is used.
//  - write_data_array = (state==FILL) & memory_data_valid.
//    - fill_addr = base + {recv_cnt, 1'b0}; recv_cnt increments on each valid word.
//  - write_tag_array is asserted in the same cycle as the final write_data_array (recv_cnt==7 & valid).
//  - fsm_busy = (state==FILL) | (state==IDLE & miss_detected). Busy covers the detect cycle, so
//    D_stall has no gap.
//  - In IDLE: mem_rd_en, write_data_array and write_tag_array are all 0.
//    mem_addr and fill_addr hold their last value.
//  - Reset values: state=IDLE; base=0; issue_cnt=0; recv_cnt=0; fill_count=0.
//    Outputs: fsm_busy=0, mem_rd_en=0, write_data_array=0, write_tag_array=0, mem_addr=0, fill_addr=0.
//  - Boundary conditions:
//    - miss_detected dropping during FILL is ignored; the fill always completes.
//    - miss_address changes during FILL are ignored; base is already latched.
//    - memory_data_valid while in IDLE is ignored.
//    - Valid words beyond the 8th cannot occur. If they do, they are ignored because state is IDLE.
//    - miss_detected high in the tag-write cycle: it is not a new start. The FSM returns to IDLE
//      and the miss is re-sampled the next cycle, with busy held via the IDLE term.
//    - Address add wraps modulo 2^ADDR_W and never carries above bit 3.
//    - rst asserted mid-fill: immediate return to IDLE with all outputs at reset values.
//      The partially filled block is left untagged.
// CONFIGURATION
//  FILL_STATS_EN defined:
//    - fill_count port exists.
//    - Increments by 1 on each write_tag_array cycle and saturates at 16'hFFFF.
//  FILL_STATS_EN undefined:
//    - Port and counter are absent.
//    - All other behaviour is identical.
// TESTING
//  1. Reset, idle 5 cycles -> all outputs 0, fsm_busy 0, no mem_rd_en.
//  2. Miss at 0x1236, memory valid 4 cycles after each read:
//     - mem_addr 0x1230..0x123E on cycles 1-8.
//     - write_data_array on cycles 5-12, fill_addr 0x1230..0x123E.
//     - write_tag_array on cycle 12 only; busy on cycles 0-12.
//  3. Miss held high, then a second miss at 0xFFFE right after completion:
//     - busy stays high continuously.
//     - Second fill reads 0xFFF0..0xFFFE; no carry out of the base.
//  4. Valid pulses with gaps (2-cycle bubbles between words) ->
//     - fill_addr advances only on valid; tag written with the 8th word.
//  5. rst pulsed low during cycle 6 of a fill ->
//     - Outputs zero immediately; a new miss afterwards restarts at word 0.
//  6. FILL_STATS_EN: three fills -> fill_count=3. Preload 16'hFFFF and fill once -> stays 16'hFFFF.

Source files
------------

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: fetches a 16-byte block as 8 pipelined 16-bit reads and steers returned words into the cache.
// Optional FILL_STATS_EN adds a saturating completed-fill counter on port fill_count.
module cache_fill_fsm #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int ADDR_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              memory_data_valid,
    output logic              fsm_busy,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] fill_addr,
    output logic              write_data_array,
    output logic              write_tag_array
`ifdef FILL_STATS_EN
    ,
    output logic [15:0]       fill_count
`endif
);
    localparam int CW = $clog2(WORDS_PER_BLOCK) + 1;

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] mem_addr_q, fill_addr_q;
    logic [CW-1:0]     issue_q, issue_d, recv_q, recv_d;

    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        issue_d          = issue_q;
        recv_d           = recv_q;
        mem_rd_en        = (state_q == FILL) && (issue_q < CW'(WORDS_PER_BLOCK));
        write_data_array = (state_q == FILL) && memory_data_valid;
        write_tag_array  = write_data_array && (recv_q == CW'(WORDS_PER_BLOCK - 1));
        // busy is forced low while rst is asserted so a held miss cannot leak through
        fsm_busy         = rst && ((state_q == FILL) || miss_detected);
        mem_addr         = mem_rd_en ? base_q + ADDR_W'({issue_q, 1'b0}) : mem_addr_q;
        fill_addr        = write_data_array ? base_q + ADDR_W'({recv_q, 1'b0}) : fill_addr_q;
        if (state_q == IDLE && miss_detected) begin
            state_d = FILL;
            base_d  = miss_address & ~ADDR_W'(15);
            issue_d = '0;
            recv_d  = '0;
        end else begin
            if (mem_rd_en) issue_d = issue_q + 1'b1;
            if (write_data_array) recv_d = recv_q + 1'b1;
            if (write_tag_array) state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            issue_q     <= '0;
            recv_q      <= '0;
            mem_addr_q  <= '0;
            fill_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            issue_q     <= issue_d;
            recv_q      <= recv_d;
            mem_addr_q  <= mem_addr;
            fill_addr_q <= fill_addr;
        end
    end

`ifdef FILL_STATS_EN
    logic [15:0] fill_count_q, fill_count_d;

    always_comb begin
        fill_count_d = (write_tag_array && fill_count_q != 16'hFFFF) ? fill_count_q + 16'd1 : fill_count_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) fill_count_q <= '0;
        else      fill_count_q <= fill_count_d;
    end

    assign fill_count = fill_count_q;
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: directed fills against a latency-driven memory model and an address scoreboard.
module tb_cache_fill_fsm;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] maddr = 16'h0;
    logic        fsm_busy, mem_rd_en, write_data_array, write_tag_array;
    logic [15:0] mem_addr, fill_addr;
`ifdef FILL_STATS_EN
    logic [15:0] fill_count;
`endif

    cache_fill_fsm dut (
        .clk(clk), .rst(rst), .miss_detected(miss), .miss_address(maddr),
        .memory_data_valid(valid), .fsm_busy(fsm_busy), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .fill_addr(fill_addr), .write_data_array(write_data_array),
        .write_tag_array(write_tag_array)
`ifdef FILL_STATS_EN
        , .fill_count(fill_count)
`endif
    );

    always #5 clk = ~clk;

    int          cmps = 0, errs = 0, cyc_n = 0;
    int          lat = 4, gap = 1, last_ret = 0;
    int          start_cyc = 0, tag_cyc = 0, wr_first = 0;
    logic [15:0] exp_rd[$], exp_wr[$];
    int          ret_q[$];
    bit          in_fill = 1'b0;
    logic [15:0] last_rd = 16'h0, last_fill = 16'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmps++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic m, input logic [15:0] a, input logic xv);
        logic        mv, st, we;
        logic [15:0] e;
        int          nxt;
        mv = ret_q.size() > 0 && ret_q[0] == cyc_n;
        if (mv) void'(ret_q.pop_front());
        st = !in_fill && m;
        miss = m; maddr = a; valid = mv | xv;
        @(negedge clk);
        chk("busy", fsm_busy, in_fill | m);
        chk("rd_en", mem_rd_en, in_fill && exp_rd.size() > 0);
        if (mem_rd_en && exp_rd.size() > 0) begin
            e = exp_rd.pop_front();
            chk("mem_addr", mem_addr, e);
            last_rd = e;
            nxt = (cyc_n + lat > last_ret + gap) ? cyc_n + lat : last_ret + gap;
            ret_q.push_back(nxt);
            last_ret = nxt;
        end else chk("mem_addr_hold", mem_addr, last_rd);
        we = in_fill && valid;
        chk("wr_en", write_data_array, we);
        if (we) begin
            if (exp_wr.size() == 8) wr_first = cyc_n;
            e = exp_wr.pop_front();
            chk("fill_addr", fill_addr, e);
            last_fill = e;
            chk("tag", write_tag_array, exp_wr.size() == 0);
            if (exp_wr.size() == 0) begin
                in_fill = 1'b0;
                tag_cyc = cyc_n;
            end
        end else begin
            chk("fill_addr_hold", fill_addr, last_fill);
            chk("tag_idle", write_tag_array, 1'b0);
        end
        if (st) begin
            in_fill = 1'b1;
            start_cyc = cyc_n;
            last_ret = cyc_n;
            for (int i = 0; i < 8; i++) begin
                exp_rd.push_back((a & 16'hFFF0) + 16'(2 * i));
                exp_wr.push_back((a & 16'hFFF0) + 16'(2 * i));
            end
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic fill(input logic [15:0] a, input logic hold);
        cyc(1'b1, a, 1'b0);
        for (int i = 0; i < 80 && in_fill; i++) cyc(hold, 16'($urandom), 1'b0);
        if (in_fill) chk("fill_timeout", in_fill, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b0; miss = 1'b0; valid = 1'b0;
        #1;
        chk("rst_busy", fsm_busy, 1'b0);
        chk("rst_rd_en", mem_rd_en, 1'b0);
        chk("rst_wr", write_data_array, 1'b0);
        chk("rst_tag", write_tag_array, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0);
        chk("rst_fill_addr", fill_addr, 16'h0);
`ifdef FILL_STATS_EN
        chk("rst_fill_count", fill_count, 16'h0);
`endif
        exp_rd.delete(); exp_wr.delete(); ret_q.delete();
        in_fill = 1'b0; last_rd = 16'h0; last_fill = 16'h0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc_n++;
    endtask

    initial begin
        #2;
        do_reset();
        // 1: idle with stray valid pulses
        repeat (5) cyc(1'b0, 16'($urandom), 1'b1);
        // 2: miss at 0x1236, latency 4
        fill(16'h1236, 1'b0);
        chk("t2_first_wr", wr_first - start_cyc, 5);
        chk("t2_tag_cyc", tag_cyc - start_cyc, 12);
        cyc(1'b0, 16'h0, 1'b1);
        chk("t2_mem_addr_end", mem_addr, 16'h123E);
        chk("t2_fill_addr_end", fill_addr, 16'h123E);
        // 3: miss held through the tag cycle, back-to-back fill at the top of memory
        fill(16'h5558, 1'b1);
        fill(16'hFFFE, 1'b1);
        cyc(1'b0, 16'h0, 1'b0);
        chk("t3_mem_addr_end", mem_addr, 16'hFFFE);
        chk("t3_fill_addr_end", fill_addr, 16'hFFFE);
        // 4: two-cycle bubbles between returning words
        lat = 2; gap = 3;
        fill(16'h0A1F, 1'b0);
        chk("t4_tag_cyc", tag_cyc - start_cyc, 24);
        lat = 4; gap = 1;
        // 5: reset during cycle 6 of a fill
        cyc(1'b1, 16'h0300, 1'b0);
        repeat (5) cyc(1'b0, 16'h0, 1'b0);
        do_reset();
        fill(16'h0044, 1'b0);
        chk("t5_fill_addr_end", fill_addr, 16'h004E);
`ifdef FILL_STATS_EN
        fill(16'h2000, 1'b0);
        fill(16'h3000, 1'b0);
        cyc(1'b0, 16'h0, 1'b0);
        chk("t6_count3", fill_count, 16'd3);
        force dut.fill_count_q = 16'hFFFF;
        #1;
        release dut.fill_count_q;
        fill(16'h4000, 1'b0);
        cyc(1'b0, 16'h0, 1'b0);
        chk("t6_saturate", fill_count, 16'hFFFF);
`endif
        repeat (2) cyc(1'b0, 16'h0, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end
endmodule
